// File: rtl/programmable_tick_gen.sv
// Programmable multi-channel tick generator.
// Each channel counts clk cycles against a programmable period and emits a
// one-cycle tick at every wrap (periodic mode) or once (one-shot mode).
// Period writes land in a shadow register and only reach the active period
// at a start or at the next wrap, so a running period is never disturbed.
module programmable_tick_gen #(
    parameter int WIDTH          = 20,
    parameter int CHANNELS       = 4,
    parameter int DEFAULT_PERIOD = 1000000,
    localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_period,
    input  logic [CHANNELS-1:0] start,
    input  logic [CHANNELS-1:0] stop,
    input  logic [CHANNELS-1:0] oneshot,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] running
);

    localparam logic [WIDTH-1:0] DEF_PERIOD = WIDTH'(DEFAULT_PERIOD);

    // A zero period is meaningless and is dropped. Out-of-range channel
    // indices are dropped implicitly because no channel decodes them.
    logic wr_valid;
    assign wr_valid = wr_en && (wr_period != '0);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [WIDTH-1:0] shadow_reg, shadow_next;
        logic [WIDTH-1:0] active_reg, active_next;
        logic [WIDTH-1:0] count_reg, count_next;
        logic             mode_reg, mode_next;
        logic             run_reg, run_next;
        logic             tick_reg, tick_next;
        logic             wr_hit;
        logic             terminal;

        assign wr_hit   = wr_valid && (wr_ch == CH_W'(gi));
        assign terminal = run_reg && (count_reg == active_reg - WIDTH'(1));

        // Next-state: stop beats start, start beats terminal count, and the
        // shadow value seen by start/wrap already includes a same-edge write.
        always_comb begin
            shadow_next = wr_hit ? wr_period : shadow_reg;
            active_next = active_reg;
            count_next  = count_reg;
            mode_next   = mode_reg;
            run_next    = run_reg;
            tick_next   = 1'b0;
            if (stop[gi]) begin
                run_next   = 1'b0;
                count_next = '0;
            end else if (start[gi]) begin
                active_next = shadow_next;
                mode_next   = oneshot[gi];
                count_next  = '0;
                run_next    = 1'b1;
            end else if (terminal) begin
                count_next  = '0;
                active_next = shadow_next;
                tick_next   = 1'b1;
                if (mode_reg) begin
                    run_next = 1'b0;
                end
            end else if (run_reg) begin
                count_next = count_reg + WIDTH'(1);
            end
        end

        // Channel state register; reset aborts any period in flight.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                shadow_reg <= DEF_PERIOD;
                active_reg <= DEF_PERIOD;
                count_reg  <= '0;
                mode_reg   <= 1'b0;
                run_reg    <= 1'b0;
                tick_reg   <= 1'b0;
            end else begin
                shadow_reg <= shadow_next;
                active_reg <= active_next;
                count_reg  <= count_next;
                mode_reg   <= mode_next;
                run_reg    <= run_next;
                tick_reg   <= tick_next;
            end
        end

        assign tick[gi]    = tick_reg;
        assign running[gi] = run_reg;
    end

endmodule

// File: tb/tb_programmable_tick_gen.sv
// Scoreboard bench for programmable_tick_gen. The reference model tracks,
// per channel, the absolute cycle at which the next tick is due.
module tb_programmable_tick_gen;

    localparam int WIDTH = 12;
    localparam int CH    = 5;
    localparam int DEFP  = 25;
    localparam int CH_W  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            wr_en = 1'b0;
    logic [CH_W-1:0] wr_ch = '0;
    logic [WIDTH-1:0] wr_period = '0;
    logic [CH-1:0]   start = '0;
    logic [CH-1:0]   stop = '0;
    logic [CH-1:0]   oneshot = '0;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   running;

    programmable_tick_gen #(
        .WIDTH(WIDTH), .CHANNELS(CH), .DEFAULT_PERIOD(DEFP)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_period(wr_period), .start(start), .stop(stop),
        .oneshot(oneshot), .tick(tick), .running(running)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mon_cyc = 0;

    // Reference model state
    int     shadow_m[CH];
    int     active_m[CH];
    longint next_m[CH];
    bit     run_m[CH];
    bit     mode_m[CH];
    longint cyc = 0;
    logic [2*CH-1:0] exp_q[$];

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            shadow_m[i] = DEFP;
            active_m[i] = DEFP;
            next_m[i]   = 0;
            run_m[i]    = 1'b0;
            mode_m[i]   = 1'b0;
        end
    endtask

    // Predict outputs after the coming edge, push them, then take the edge.
    task automatic step();
        logic [CH-1:0] et;
        logic [CH-1:0] er;
        int            sh_new;
        et = '0;
        er = '0;
        cyc++;
        if (!rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < CH; i++) begin
                sh_new = (wr_en && wr_period != 0 && int'(wr_ch) == i) ? int'(wr_period) : shadow_m[i];
                if (stop[i]) begin
                    run_m[i] = 1'b0;
                end else if (start[i]) begin
                    run_m[i]    = 1'b1;
                    mode_m[i]   = oneshot[i];
                    active_m[i] = sh_new;
                    next_m[i]   = cyc + sh_new;
                end else if (run_m[i] && cyc == next_m[i]) begin
                    et[i]       = 1'b1;
                    active_m[i] = sh_new;
                    next_m[i]   = cyc + sh_new;
                    if (mode_m[i]) run_m[i] = 1'b0;
                end
                shadow_m[i] = sh_new;
                er[i] = run_m[i];
            end
        end
        exp_q.push_back({et, er});
        @(posedge clk);
        #2;
        start = '0;
        stop  = '0;
        wr_en = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk(input string name, input logic [CH-1:0] got, input logic [CH-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, req);
        end
    endtask

    task automatic write(input int ch, input int p);
        wr_en     = 1'b1;
        wr_ch     = CH_W'(ch);
        wr_period = WIDTH'(p);
    endtask

    // Monitor: outputs are presented every cycle; compare after each edge.
    always @(negedge clk) begin
        logic [2*CH-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mon_cyc++;
            checks++;
            if ({tick, running} !== e) begin
                errors++;
                $display("FAIL scoreboard cycle %0d: got tick=%b running=%b, expected tick=%b running=%b",
                         mon_cyc, tick, running, e[2*CH-1:CH], e[CH-1:0]);
            end
        end
    end

    initial begin
        model_reset();
        #1;
        chk("reset_tick", tick, '0);
        chk("reset_running", running, '0);
        steps(3);
        rst = 1'b1;

        $display("txn: start ch0 default period %0d", DEFP);
        start[0] = 1'b1;
        step();
        steps(DEFP + 3);
        stop[0] = 1'b1;
        step();

        $display("txn: ch1 period 4 periodic");
        write(1, 4);
        step();
        start[1] = 1'b1;
        step();
        steps(13);

        $display("txn: ch1 restart, rewrite period 6 at count 1");
        start[1] = 1'b1;
        step();
        step();
        write(1, 6);
        step();
        steps(22);
        stop[1] = 1'b1;
        step();

        $display("txn: ch2 period 3 one-shot");
        write(2, 3);
        step();
        start[2]   = 1'b1;
        oneshot[2] = 1'b1;
        step();
        oneshot = '0;
        steps(8);

        $display("txn: ch3 start+stop same edge, ignored writes");
        start[3] = 1'b1;
        stop[3]  = 1'b1;
        step();
        steps(3);
        write(3, 0);
        step();
        write(6, 2);
        step();
        write(7, 3);
        step();
        start[3] = 1'b1;
        step();
        steps(DEFP + 3);
        stop[3] = 1'b1;
        step();

        $display("txn: ch4 write and start on the same edge");
        write(4, 2);
        start[4] = 1'b1;
        step();
        steps(6);

        $display("txn: ch0 period 1 periodic");
        write(0, 1);
        step();
        start[0] = 1'b1;
        step();
        steps(5);

        $display("txn: mid-period asynchronous reset");
        start = '1;
        step();
        steps(2);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("async_reset_tick", tick, '0);
        chk("async_reset_running", running, '0);
        steps(2);
        rst = 1'b1;
        steps(30);

        $display("txn: random traffic");
        for (int n = 0; n < 3000; n++) begin
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_ch     = CH_W'($urandom_range(0, 7));
            wr_period = WIDTH'($urandom_range(0, 9));
            for (int i = 0; i < CH; i++) begin
                start[i]   = ($urandom_range(0, 15) == 0);
                stop[i]    = ($urandom_range(0, 39) == 0);
                oneshot[i] = 1'($urandom_range(0, 1));
            end
            step();
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
